// File: rtl/butterfly_addsub_pkg.sv
// Shared FFT definitions: butterfly output-processing mode encodings.
// Also imported by the butterfly controller.
package butterfly_addsub_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP  = 2'b00,
    MODE_SAT   = 2'b01,
    MODE_SCALE = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

endpackage

// File: rtl/butterfly_addsub_split_carry_adder.sv
// N-bit ripple adder slice with carry in/out, used to split a wide add
// across pipeline stages.
module split_carry_adder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  assign {cout, s} = (N+1)'(a) + (N+1)'(b) + (N+1)'(cin);

endmodule

// File: rtl/butterfly_addsub.sv
// Two-stage pipelined butterfly add/subtract with wrap, saturate and scale
// output modes, valid/ready handshake and a sticky overflow flag.
module butterfly_addsub
  import butterfly_addsub_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LO_BITS = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_diff,
  output logic [1:0]       out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam int unsigned HI_BITS = WIDTH - LO_BITS;

  // Stage 1 registers
  logic [LO_BITS-1:0] s1_sum_lo_q, s1_sum_lo_d;
  logic [LO_BITS-1:0] s1_diff_lo_q, s1_diff_lo_d;
  logic               s1_sum_cy_q, s1_sum_cy_d;
  logic               s1_diff_cy_q, s1_diff_cy_d;
  logic [HI_BITS-1:0] s1_a_hi_q, s1_a_hi_d;
  logic [HI_BITS-1:0] s1_b_hi_q, s1_b_hi_d;
  mode_e              s1_mode_q, s1_mode_d;
  logic               s1_valid_q, s1_valid_d;

  // Stage 2 (output) registers
  logic [WIDTH-1:0]   out_sum_q, out_sum_d;
  logic [WIDTH-1:0]   out_diff_q, out_diff_d;
  logic [1:0]         out_ovf_q, out_ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               ovf_sticky_q, ovf_sticky_d;

  logic               advance;
  logic [LO_BITS-1:0] sum_lo, diff_lo;
  logic               sum_lo_cy, diff_lo_cy;
  logic [HI_BITS-1:0] sum_hi, diff_hi;
  logic               sum_hi_cy, diff_hi_cy;
  logic [WIDTH:0]     sum_full, diff_full;
  logic [WIDTH:0]     sum_post, diff_post;

  assign advance = ~out_valid_q | out_ready;

  split_carry_adder #(.N(LO_BITS)) u_sum_lo (
    .a(in_a[LO_BITS-1:0]), .b(in_b[LO_BITS-1:0]), .cin(1'b0),
    .s(sum_lo), .cout(sum_lo_cy)
  );

  split_carry_adder #(.N(LO_BITS)) u_diff_lo (
    .a(in_a[LO_BITS-1:0]), .b(~in_b[LO_BITS-1:0]), .cin(1'b1),
    .s(diff_lo), .cout(diff_lo_cy)
  );

  split_carry_adder #(.N(HI_BITS)) u_sum_hi (
    .a(s1_a_hi_q), .b(s1_b_hi_q), .cin(s1_sum_cy_q),
    .s(sum_hi), .cout(sum_hi_cy)
  );

  split_carry_adder #(.N(HI_BITS)) u_diff_hi (
    .a(s1_a_hi_q), .b(~s1_b_hi_q), .cin(s1_diff_cy_q),
    .s(diff_hi), .cout(diff_hi_cy)
  );

  // Extra MSB of the sign-extended add is sign_a ^ sign_b ^ carry out of the top bit.
  assign sum_full  = {s1_a_hi_q[HI_BITS-1] ^ s1_b_hi_q[HI_BITS-1] ^ sum_hi_cy,
                      sum_hi, s1_sum_lo_q};
  assign diff_full = {s1_a_hi_q[HI_BITS-1] ^ ~s1_b_hi_q[HI_BITS-1] ^ diff_hi_cy,
                      diff_hi, s1_diff_lo_q};

  // Returns {ovf, result} for one exact WIDTH+1-bit value.
  function automatic logic [WIDTH:0] post_proc(input logic [WIDTH:0] full,
                                               input mode_e mode);
    logic             of;
    logic [WIDTH-1:0] r;
    of = full[WIDTH] ^ full[WIDTH-1];
    r  = full[WIDTH-1:0];
    case (mode)
      MODE_SAT: begin
        if (of) r = full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
      MODE_SCALE: begin
        r  = full[WIDTH:1];
        of = 1'b0;
      end
      default: ;
    endcase
    return {of, r};
  endfunction

  assign sum_post  = post_proc(sum_full, s1_mode_q);
  assign diff_post = post_proc(diff_full, s1_mode_q);

  always_comb begin
    s1_sum_lo_d  = s1_sum_lo_q;
    s1_diff_lo_d = s1_diff_lo_q;
    s1_sum_cy_d  = s1_sum_cy_q;
    s1_diff_cy_d = s1_diff_cy_q;
    s1_a_hi_d    = s1_a_hi_q;
    s1_b_hi_d    = s1_b_hi_q;
    s1_mode_d    = s1_mode_q;
    s1_valid_d   = s1_valid_q;
    out_sum_d    = out_sum_q;
    out_diff_d   = out_diff_q;
    out_ovf_d    = out_ovf_q;
    out_valid_d  = out_valid_q;
    ovf_sticky_d = ovf_sticky_q;

    if (advance) begin
      s1_sum_lo_d  = sum_lo;
      s1_diff_lo_d = diff_lo;
      s1_sum_cy_d  = sum_lo_cy;
      s1_diff_cy_d = diff_lo_cy;
      s1_a_hi_d    = in_a[WIDTH-1:LO_BITS];
      s1_b_hi_d    = in_b[WIDTH-1:LO_BITS];
      s1_mode_d    = mode_e'(in_mode);
      s1_valid_d   = in_valid;
      out_sum_d    = sum_post[WIDTH-1:0];
      out_diff_d   = diff_post[WIDTH-1:0];
      out_ovf_d    = {diff_post[WIDTH], sum_post[WIDTH]};
      out_valid_d  = s1_valid_q;
    end

    // Set on an overflowing output transfer wins over a concurrent clear.
    if (out_valid_q && out_ready && (out_ovf_q != 2'b00)) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sum_lo_q  <= '0;
      s1_diff_lo_q <= '0;
      s1_sum_cy_q  <= 1'b0;
      s1_diff_cy_q <= 1'b0;
      s1_a_hi_q    <= '0;
      s1_b_hi_q    <= '0;
      s1_mode_q    <= MODE_WRAP;
      s1_valid_q   <= 1'b0;
      out_sum_q    <= '0;
      out_diff_q   <= '0;
      out_ovf_q    <= 2'b00;
      out_valid_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_sum_lo_q  <= s1_sum_lo_d;
      s1_diff_lo_q <= s1_diff_lo_d;
      s1_sum_cy_q  <= s1_sum_cy_d;
      s1_diff_cy_q <= s1_diff_cy_d;
      s1_a_hi_q    <= s1_a_hi_d;
      s1_b_hi_q    <= s1_b_hi_d;
      s1_mode_q    <= s1_mode_d;
      s1_valid_q   <= s1_valid_d;
      out_sum_q    <= out_sum_d;
      out_diff_q   <= out_diff_d;
      out_ovf_q    <= out_ovf_d;
      out_valid_q  <= out_valid_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign in_ready   = advance;
  assign out_sum    = out_sum_q;
  assign out_diff   = out_diff_q;
  assign out_ovf    = out_ovf_q;
  assign out_valid  = out_valid_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: doc/butterfly_addsub.md
BUTTERFLY_ADDSUB -- requirements
Module: butterfly_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, signed operand/result width; legal range 4..32.
REQ-002 SHALL have parameter LO_BITS, default WIDTH/2, the number of low bits added in stage 1; legal range 1..WIDTH-1.
REQ-003 SHALL provide port clk, input, 1 bit; the single clock, all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL provide port in_a, input, WIDTH bits; two's-complement operand A.
REQ-006 SHALL provide port in_b, input, WIDTH bits; two's-complement operand B.
REQ-007 SHALL provide port in_mode, input, 2 bits; 00 wrap, 01 saturate, 10 scale-by-half, 11 treated as wrap.
REQ-008 SHALL provide port in_valid, input, 1 bit; operands and mode are valid.
REQ-009 SHALL provide port in_ready, output, 1 bit; the block accepts the operands this cycle.
REQ-010 SHALL provide port out_sum, output, WIDTH bits; the processed A+B.
REQ-011 SHALL provide port out_diff, output, WIDTH bits; the processed A-B.
REQ-012 SHALL provide port out_ovf, output, 2 bits; bit0 flags sum overflow, bit1 flags diff overflow.
REQ-013 SHALL provide port out_valid, output, 1 bit; the outputs are valid.
REQ-014 SHALL provide port out_ready, input, 1 bit; the downstream accepts the outputs.
REQ-015 SHALL provide port ovf_sticky, output, 1 bit; OR of every out_ovf bit delivered since the last clear.
REQ-016 SHALL provide port ovf_clr, input, 1 bit; clears ovf_sticky.

Function
REQ-017 SHALL transfer an input when in_valid and in_ready are both 1, and an output when out_valid and out_ready are both 1.
REQ-018 SHALL form a two-stage pipeline (S1, S2) with a fixed latency of 2 cycles from input transfer to out_valid when out_ready stays 1.
REQ-019 SHALL advance the pipeline when out_valid is 0 or out_ready is 1; in_ready SHALL equal that advance condition, combinationally.
REQ-020 SHALL stall by holding both stages (data, mode and valid) unchanged when the pipeline does not advance; no transfer is lost or duplicated.
REQ-021 SHALL in S1 add the low LO_BITS of A and B, and of A and ~B with carry-in 1, registering the partial results, their carries, the upper operand bits, the mode and the valid bit.
REQ-022 SHALL in S2 complete the upper bits using the registered carries, forming exact WIDTH+1-bit signed sum and diff.
REQ-023 SHALL in wrap mode output the low WIDTH bits; ovf is set when the WIDTH+1-bit result does not fit in WIDTH bits.
REQ-024 SHALL in saturate mode clamp overflowing results to +2^(WIDTH-1)-1 or -2^(WIDTH-1); ovf is set exactly when clamping occurs.
REQ-025 SHALL in scale mode output bits [WIDTH:1] of the WIDTH+1-bit result (arithmetic shift right, truncation toward minus infinity); ovf is always 0.
REQ-026 SHALL set ovf_sticky on an output transfer with any out_ovf bit set; ovf_clr SHALL clear it, and when both occur in the same cycle the set wins.
REQ-027 SHALL register all outputs; out_sum, out_diff and out_ovf are undefined-but-stable when out_valid is 0.
REQ-028 SHALL accept a new input in the same cycle an output transfers, sustaining one result per cycle.

Reset
REQ-029 SHALL on rst clear both stage valid bits, out_valid, out_sum, out_diff, out_ovf and ovf_sticky to 0; rst dominates every other input.
REQ-030 SHALL on rst asserted mid-operation discard in-flight data; the first cycle after rst SHALL show out_valid 0 and in_ready 1.

Structure
REQ-031 SHALL take the mode encodings (MODE_WRAP, MODE_SAT, MODE_SCALE) from the shared FFT package, also used by the butterfly controller.
REQ-032 SHALL instantiate one sub-module, split_carry_adder (parameter N, inputs a, b and cin, outputs s and cout), used for the four S1/S2 partial adds.

Verification
REQ-033 SHALL pass this directed test: WIDTH=8, wrap, A=0xB5, B=0xD3 -> 2 cycles later sum 0x88, diff 0xE2, ovf 00.
REQ-034 SHALL pass this directed test: A=0x64, B=0x64 -> wrap gives sum 0xC8, ovf 01; saturate gives sum 0x7F, ovf 01, diff 0x00; ovf_sticky is then 1.
REQ-035 SHALL pass this directed test: scale, A=0xB5, B=0xD3 -> sum 0xC4, diff 0xF1; scale, A=0x7F, B=0x80 -> sum 0xFF, diff 0x7F, ovf 00.
REQ-036 SHALL pass this directed test: stream 6 inputs with out_ready held 0 for cycles 3-5 -> in_ready 0 while stalled, 6 outputs in order, none lost or repeated.
REQ-037 SHALL pass this directed test: rst pulsed 1 cycle with 2 inputs in flight -> no out_valid afterwards, ovf_sticky 0, next input result after 2 cycles.
REQ-038 SHALL pass this directed test: ovf_clr in the same cycle as an overflowing output transfer -> ovf_sticky stays 1.
